adder_ring_meter: RTL
=====================

// Module: adder_ring_meter
// PURPOSE
//  Measurement controller that sits inside wrapped_project, directly behind the LA/IO buffering.
//  It enables the instrumented-adder ring oscillator for a programmed number of system clocks.
//  It counts rising edges of the pre-divided ring output over that window.
//  It returns the count and status to the LA outputs for the PicoRV32 to read.
// PARAMETERS
//  WIN_W    16  width of window length (system clocks)
//  CNT_W    24  width of edge counter
//  SETTLE   8   ring settle cycles before counting (used only with RING_SETTLE_EN)
// PORTS
//  wb_clk_i     in   1      system clock; all logic on rising edge
//  wb_rst_n     in   1      reset, synchronous, active-low
//  start_i      in   1      level; sampled high in IDLE starts a measurement
//  abort_i      in   1      level; forces return to IDLE from any state
//  window_i     in   WIN_W  window length in clocks, latched on accepted start
//  ring_div_i   in   1      divided ring output, asynchronous, period >= 2 clocks
//  ring_en_o    out  1      ring oscillator enable
//  busy_o       out  1      high in any state other than IDLE
//  done_o       out  1      one-cycle pulse at the end of a completed window
//  overflow_o   out  1      counter saturated during the last measurement
//  count_o      out  CNT_W  edges counted; held until the next accepted start
// BEHAVIOUR
//  Reset (wb_rst_n=0 at a clock edge):
//   state=IDLE; all outputs 0; synchroniser flops, timer and latched window are 0.
//   Reset overrides everything, including mid-run.
//  Synchroniser: ring_div_i -> s1 -> s2 -> s3, running every cycle.
//   rise = s2 & ~s3.
//  States:
//   IDLE: ring_en=0, busy=0.
//    start_i=1 and abort_i=0 -> latch window_i, clear count/overflow.
//    If window_i==0 -> DONE, else -> SETTLE (macro on) / RUN (macro off).
//   SETTLE: ring_en=1, no counting; lasts exactly SETTLE cycles, then -> RUN.
//   RUN: ring_en=1; lasts exactly window cycles; count += rise every RUN cycle.
//    Counter saturates at 2^CNT_W-1; a rise seen while saturated sets overflow_o (sticky).
//    After the last RUN cycle -> DONE.
//   DONE: ring_en=0, done_o=1 for this one cycle, busy=1; -> IDLE.
//  Latency, macro off:
//   start sampled at edge t.
//   RUN occupies cycles t+1..t+W; done_o is high in cycle t+W+1.
//   Back in IDLE at t+W+2; a new start can be accepted at that edge.
//  abort_i=1 in SETTLE/RUN/DONE: next state IDLE, ring_en=0, no done pulse.
//   count_o/overflow_o keep their partial values.
//  Start is ignored when busy. window_i changes after the latch have no effect.
//  Simultaneous start and abort in IDLE: abort wins, stay in IDLE.
//  A rise in the same cycle as the RUN->DONE transition is counted; rises in DONE/IDLE are not.
// CONFIGURATION
//  RING_SETTLE_EN defined:
//   SETTLE state present; ring runs SETTLE cycles before RUN.
//   done_o moves to t+SETTLE+W+1.
//  RING_SETTLE_EN undefined:
//   no SETTLE state; IDLE goes straight to RUN.
//   The SETTLE parameter is ignored.
// TESTING
//  1 Macro off, W=100, ring_div period 4 clocks -> count_o=25, overflow_o=0, done_o high exactly at t+101.
//  2 CNT_W=4, W=100, period 2 -> count_o=15, overflow_o=1, done_o still at t+101.
//  3 W=0 -> done_o at t+1, count_o=0, ring_en_o never high.
//  4 W=1000, abort_i at RUN cycle 40, period 4 -> IDLE next cycle, no done_o, count_o=10 (+/-1 phase).
//  5 start_i held high through a W=10 run -> a second run begins at t+12; each run gives one done_o.
//  6 wb_rst_n low mid-run -> next cycle all outputs 0, state IDLE.
//    With RING_SETTLE_EN, SETTLE=8, W=10 -> done_o at t+19.

Source files
------------

// File: rtl/adder_ring_meter.sv
// adder_ring_meter: gates the adder ring oscillator for a programmed window and counts divided ring edges.
// Define RING_SETTLE_EN to let the ring run SETTLE cycles before counting starts.
module adder_ring_meter #(
  parameter int WIN_W  = 16,
  parameter int CNT_W  = 24,
  parameter int SETTLE = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIN_W-1:0] window_i,
  input  logic             ring_div_i,
  output logic             ring_en_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             overflow_o,
  output logic [CNT_W-1:0] count_o
);
`ifdef RING_SETTLE_EN
  localparam bit settle_on = 1'b1;
`else
  localparam bit settle_on = 1'b0;
`endif
  localparam bit use_settle = settle_on && (SETTLE != 0);
  typedef enum logic [1:0] {IDLE, SETTLE_S, RUN, DONE} state_t;
  state_t state;
  logic s1, s2, s3;
  logic [WIN_W-1:0] win, timer;
  logic rise, sat;
  assign rise = s2 & ~s3;
  assign sat  = &count_o;
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state      <= IDLE;
      {s1, s2, s3} <= 3'b000;
      win        <= '0;
      timer      <= '0;
      ring_en_o  <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      overflow_o <= 1'b0;
      count_o    <= '0;
    end else begin
      {s1, s2, s3} <= {ring_div_i, s1, s2};
      done_o <= 1'b0;
      if (abort_i && state != IDLE) begin
        state     <= IDLE;
        ring_en_o <= 1'b0;
        busy_o    <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start_i && !abort_i) begin
            win        <= window_i;
            count_o    <= '0;
            overflow_o <= 1'b0;
            busy_o     <= 1'b1;
            if (window_i == '0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state     <= use_settle ? SETTLE_S : RUN;
              timer     <= use_settle ? WIN_W'(SETTLE) : window_i;
              ring_en_o <= 1'b1;
            end
          end
          SETTLE_S: begin
            state <= (timer == 1) ? RUN : SETTLE_S;
            timer <= (timer == 1) ? win : timer - 1'b1;
          end
          RUN: begin
            // a saturated counter holds and flags the lost edge instead of wrapping
            if (rise && sat) overflow_o <= 1'b1;
            if (rise && !sat) count_o <= count_o + 1'b1;
            if (timer == 1) begin
              state     <= DONE;
              done_o    <= 1'b1;
              ring_en_o <= 1'b0;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
